// File: rtl/ddr_lane_sched_pkg.sv
// Shared types and constants for the double-rate capture lane burst scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: FSM state enum, default burst-length field width, lane data
// width, and a one-hot helper for the two-requester grant vector.
package ddr_lane_sched_pkg;

  localparam int LEN_W_DEFAULT = 4;
  localparam int DATA_W        = 8;

  // ST_GAP only becomes reachable when the turnaround gap is compiled in.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  function automatic logic [1:0] onehot2(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ddr_lane_sched_if.sv
// Request/beat/lane bundle between the two requesters, the scheduler and the capture lane.
// Latency: n/a (wires only).
// Backpressure: none; beats are paced by gnt, the lane has no ready.
//
// master: drives req/len0/len1/data0/data1, observes gnt/done/busy and lane outputs.
// slave : the scheduler side.
interface ddr_lane_sched_if #(
  parameter int LEN_W = ddr_lane_sched_pkg::LEN_W_DEFAULT
) ();
  import ddr_lane_sched_pkg::*;

  logic [1:0]        req;
  logic [LEN_W-1:0]  len0;
  logic [LEN_W-1:0]  len1;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic [1:0]        gnt;
  logic [1:0]        done;
  logic [DATA_W-1:0] din;
  logic              din_en;
  logic              csn;
  logic              busy;

  modport master (
    output req, len0, len1, data0, data1,
    input  gnt, done, din, din_en, csn, busy
  );

  modport slave (
    input  req, len0, len1, data0, data1,
    output gnt, done, din, din_en, csn, busy
  );

endinterface

// File: rtl/ddr_lane_sched_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the one that did not win last.
// Latency: combinational, 0 cycles.
// Backpressure: none; caller decides when a win is taken.
//
// Ports: req[1:0] levels, last_owner (1 = requester 1 won last), win[1:0] one-hot or zero.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last_owner ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/ddr_lane_sched.sv
// Round-robin burst scheduler feeding din/din_en/csn of the double-rate capture lane.
// Latency: req in IDLE -> gnt next cycle; lane outputs lag gnt by exactly 1 cycle.
// Backpressure: none; a granted burst always runs len+1 consecutive beats.
//
// Ports: clk, rst (sync, active-high), bus (ddr_lane_sched_if.slave):
//   req/len0/len1/data0/data1 in; gnt/done/busy combinational from state;
//   din/din_en/csn registered lane drive (csn low = requester 0 half).
// Optional: `define DDR_LANE_SCHED_GAP_EN inserts a 1-cycle GAP after each
//   burst, giving 2 din_en-low cycles for the csn turnaround.
module ddr_lane_sched
  import ddr_lane_sched_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  ddr_lane_sched_if.slave  bus
);

  state_e            state_q, state_d;
  logic              owner_q;
  logic              last_owner_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [DATA_W-1:0] din_q;
  logic              din_en_q;
  logic              csn_q;

  logic [1:0]        win;
  logic              beat;
  logic              last_beat;
  logic              grant;

  // One arbiter serves both the IDLE decision and the last-beat handover.
  rr_arb2 u_arb (
    .req        (bus.req),
    .last_owner (last_owner_q),
    .win        (win)
  );

  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    beat      = (state_q == ST_BURST);
    last_beat = beat && (cnt_q == len_q);
    case (state_q)
      ST_IDLE: begin
        if (|win) begin
          state_d = ST_BURST;
          grant   = 1'b1;
        end
      end
      ST_BURST: begin
        if (last_beat) begin
`ifdef DDR_LANE_SCHED_GAP_EN
          state_d = ST_GAP;
`else
          // Arbitrate on this cycle's req so the next burst follows with no bubble.
          if (|win) begin
            state_d = ST_BURST;
            grant   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
`endif
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.gnt    = beat ? onehot2(owner_q) : 2'b00;
  assign bus.done   = last_beat ? onehot2(owner_q) : 2'b00;
  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.din    = din_q;
  assign bus.din_en = din_en_q;
  assign bus.csn    = csn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      len_q        <= '0;
      cnt_q        <= '0;
      din_q        <= '0;
      din_en_q     <= 1'b0;
      csn_q        <= 1'b1;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q      <= win[1];
        last_owner_q <= win[1];
        len_q        <= win[1] ? bus.len1 : bus.len0;
        cnt_q        <= '0;
      end else if (beat && !last_beat) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end
      din_en_q <= beat;
      if (beat) begin
        din_q <= owner_q ? bus.data1 : bus.data0;
        csn_q <= owner_q;
      end
    end
  end

endmodule

// File: tb/tb_ddr_lane_sched.sv
`timescale 1ns/1ps
module tb_ddr_lane_sched;
  import ddr_lane_sched_pkg::*;

  localparam int LW   = LEN_W_DEFAULT;
  localparam int MAXC = 640;
  localparam int RN   = 600;
`ifdef DDR_LANE_SCHED_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ddr_lane_sched_if #(.LEN_W(LW)) bus ();

  ddr_lane_sched #(.LEN_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int chk_n;
  int pass_n;

  // per-cycle record of driven inputs and observed outputs
  logic          r_rst  [MAXC];
  logic [1:0]    r_req  [MAXC];
  logic [LW-1:0] r_l0   [MAXC];
  logic [LW-1:0] r_l1   [MAXC];
  logic [7:0]    r_d0   [MAXC];
  logic [7:0]    r_d1   [MAXC];
  logic [1:0]    o_gnt  [MAXC];
  logic [1:0]    o_done [MAXC];
  logic [7:0]    o_din  [MAXC];
  logic          o_en   [MAXC];
  logic          o_csn  [MAXC];
  logic          o_busy [MAXC];

  task automatic do_reset();
    rst = 1'b1;
    bus.req = 2'b00; bus.len0 = '0; bus.len1 = '0; bus.data0 = '0; bus.data1 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Drives n cycles starting just after a rising edge and records outputs at the falling edge.
  // Directed mode: data0/data1 step from 0x10/0x20 by one per granted beat.
  task automatic run_cycles(input int n, input logic [1:0] rq, input int hold,
                            input int l0, input int l1, input int rst_at, input bit rnd);
    int g0, g1;
    g0 = 0; g1 = 0;
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        rst       = (i == 0) || ($urandom_range(0, 59) == 0);
        bus.req   = 2'($urandom_range(0, 3));
        bus.len0  = LW'($urandom_range(0, (1 << LW) - 1));
        bus.len1  = LW'($urandom_range(0, (1 << LW) - 1));
        bus.data0 = 8'($urandom);
        bus.data1 = 8'($urandom);
      end else begin
        rst       = (i == rst_at);
        bus.req   = (i < hold) ? rq : 2'b00;
        bus.len0  = LW'(l0);
        bus.len1  = LW'(l1);
        bus.data0 = 8'h10 + 8'(g0);
        bus.data1 = 8'h20 + 8'(g1);
      end
      r_rst[i] = rst; r_req[i] = bus.req; r_l0[i] = bus.len0; r_l1[i] = bus.len1;
      r_d0[i] = bus.data0; r_d1[i] = bus.data1;
      @(negedge clk);
      o_gnt[i] = bus.gnt; o_done[i] = bus.done; o_din[i] = bus.din;
      o_en[i] = bus.din_en; o_csn[i] = bus.csn; o_busy[i] = bus.busy;
      if (bus.gnt[0] === 1'b1) g0++;
      if (bus.gnt[1] === 1'b1) g1++;
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    run_cycles(3, 2'b01, 3, 7, 0, -1, 1'b0);
    do_reset();
    @(negedge clk);
    chk_n++; if (bus.gnt !== 2'b00) $display("FAIL reset_gnt got=%b exp=00", bus.gnt); else pass_n++;
    chk_n++; if (bus.done !== 2'b00) $display("FAIL reset_done got=%b exp=00", bus.done); else pass_n++;
    chk_n++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else pass_n++;
    chk_n++; if (bus.din_en !== 1'b0) $display("FAIL reset_din_en got=%b exp=0", bus.din_en); else pass_n++;
    chk_n++; if (bus.csn !== 1'b1) $display("FAIL reset_csn got=%b exp=1", bus.csn); else pass_n++;
    chk_n++; if (bus.din !== 8'h00) $display("FAIL reset_din got=%h exp=00", bus.din); else pass_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_burst();
    logic [1:0] eg, ed;
    logic eb, ee;
    do_reset();
    run_cycles(8, 2'b01, 1, 3, 0, -1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      eg = (i >= 1 && i <= 4) ? 2'b01 : 2'b00;
      ed = (i == 4) ? 2'b01 : 2'b00;
      ee = (i >= 2 && i <= 5);
      eb = (i >= 1 && i <= 4) || (GAP && i == 5);
      chk_n++; if (o_gnt[i] !== eg) $display("FAIL single_gnt cyc=%0d got=%b exp=%b", i, o_gnt[i], eg); else pass_n++;
      chk_n++; if (o_done[i] !== ed) $display("FAIL single_done cyc=%0d got=%b exp=%b", i, o_done[i], ed); else pass_n++;
      chk_n++; if (o_en[i] !== ee) $display("FAIL single_din_en cyc=%0d got=%b exp=%b", i, o_en[i], ee); else pass_n++;
      chk_n++; if (o_busy[i] !== eb) $display("FAIL single_busy cyc=%0d got=%b exp=%b", i, o_busy[i], eb); else pass_n++;
    end
    for (int i = 2; i <= 5; i++) begin
      chk_n++; if (o_din[i] !== 8'(8'h10 + i - 2)) $display("FAIL single_din cyc=%0d got=%h exp=%h", i, o_din[i], 8'(8'h10 + i - 2)); else pass_n++;
      chk_n++; if (o_csn[i] !== 1'b0) $display("FAIL single_csn cyc=%0d got=%b exp=0", i, o_csn[i]); else pass_n++;
    end
  endtask

  // Tie after reset: requester 0 first, then 1; gap build inserts GAP + IDLE between.
  task automatic test_tie();
    logic [1:0] eg, ed, pg;
    logic eb;
    logic [7:0] beat_vals [4];
    int s1, nb, first_en, last_en, zeros;
    beat_vals[0] = 8'h10; beat_vals[1] = 8'h11; beat_vals[2] = 8'h20; beat_vals[3] = 8'h21;
    s1 = GAP ? 5 : 3;
    do_reset();
    run_cycles(10, 2'b11, GAP ? 5 : 3, 1, 1, -1, 1'b0);
    pg = 2'b00; nb = 0;
    for (int i = 0; i < 10; i++) begin
      eg = (i == 1 || i == 2) ? 2'b01 : (i == s1 || i == s1 + 1) ? 2'b10 : 2'b00;
      ed = (i == 2) ? 2'b01 : (i == s1 + 1) ? 2'b10 : 2'b00;
      eb = (eg != 2'b00) || (GAP && (i == 3 || i == s1 + 2));
      chk_n++; if (o_gnt[i] !== eg) $display("FAIL tie_gnt cyc=%0d got=%b exp=%b", i, o_gnt[i], eg); else pass_n++;
      chk_n++; if (o_done[i] !== ed) $display("FAIL tie_done cyc=%0d got=%b exp=%b", i, o_done[i], ed); else pass_n++;
      chk_n++; if (o_busy[i] !== eb) $display("FAIL tie_busy cyc=%0d got=%b exp=%b", i, o_busy[i], eb); else pass_n++;
      chk_n++; if (o_en[i] !== (pg != 2'b00)) $display("FAIL tie_din_en cyc=%0d got=%b exp=%b", i, o_en[i], (pg != 2'b00)); else pass_n++;
      if (pg != 2'b00 && nb < 4) begin
        chk_n++; if (o_din[i] !== beat_vals[nb]) $display("FAIL tie_din cyc=%0d got=%h exp=%h", i, o_din[i], beat_vals[nb]); else pass_n++;
        chk_n++; if (o_csn[i] !== pg[1]) $display("FAIL tie_csn cyc=%0d got=%b exp=%b", i, o_csn[i], pg[1]); else pass_n++;
        nb++;
      end
      pg = eg;
    end
    first_en = -1; last_en = -1; zeros = 0;
    for (int i = 0; i < 10; i++) if (o_en[i] === 1'b1) begin
      if (first_en < 0) first_en = i;
      last_en = i;
    end
    for (int i = 0; i < 10; i++) if (first_en >= 0 && i > first_en && i < last_en && o_en[i] !== 1'b1) zeros++;
    chk_n++; if (zeros != (GAP ? 2 : 0)) $display("FAIL tie_idle_between got=%0d exp=%0d", zeros, GAP ? 2 : 0); else pass_n++;
  endtask

  task automatic test_min_burst();
    do_reset();
    run_cycles(5, 2'b10, 1, 0, 0, -1, 1'b0);
    chk_n++; if (o_gnt[1] !== 2'b10) $display("FAIL min_gnt got=%b exp=10", o_gnt[1]); else pass_n++;
    chk_n++; if (o_done[1] !== 2'b10) $display("FAIL min_done got=%b exp=10", o_done[1]); else pass_n++;
    chk_n++; if (o_gnt[2] !== 2'b00) $display("FAIL min_gnt_after got=%b exp=00", o_gnt[2]); else pass_n++;
    chk_n++; if (o_busy[2] !== GAP) $display("FAIL min_busy_after got=%b exp=%b", o_busy[2], GAP); else pass_n++;
    chk_n++; if (o_busy[3] !== 1'b0) $display("FAIL min_idle got=%b exp=0", o_busy[3]); else pass_n++;
    chk_n++; if (o_din[2] !== 8'h20) $display("FAIL min_din got=%h exp=20", o_din[2]); else pass_n++;
    chk_n++; if (o_csn[2] !== 1'b1) $display("FAIL min_csn got=%b exp=1", o_csn[2]); else pass_n++;
    chk_n++; if (o_en[3] !== 1'b0) $display("FAIL min_din_en_after got=%b exp=0", o_en[3]); else pass_n++;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    run_cycles(5, 2'b01, 1, 7, 0, 2, 1'b0);
    chk_n++; if (o_gnt[2] !== 2'b01) $display("FAIL rmid_beat2 got=%b exp=01", o_gnt[2]); else pass_n++;
    chk_n++; if (o_en[3] !== 1'b0) $display("FAIL rmid_din_en got=%b exp=0", o_en[3]); else pass_n++;
    chk_n++; if (o_csn[3] !== 1'b1) $display("FAIL rmid_csn got=%b exp=1", o_csn[3]); else pass_n++;
    chk_n++; if (o_gnt[3] !== 2'b00) $display("FAIL rmid_gnt got=%b exp=00", o_gnt[3]); else pass_n++;
    chk_n++; if (o_busy[3] !== 1'b0) $display("FAIL rmid_busy got=%b exp=0", o_busy[3]); else pass_n++;
    run_cycles(3, 2'b11, 1, 1, 1, -1, 1'b0);
    chk_n++; if (o_gnt[1] !== 2'b01) $display("FAIL rmid_regrant got=%b exp=01", o_gnt[1]); else pass_n++;
  endtask

  task automatic test_fairness();
    int n, no, g0;
    int owners [8];
    n = GAP ? 30 : 16;
    for (int k = 0; k < 8; k++) owners[k] = -1;
    do_reset();
    run_cycles(n, 2'b11, n, 1, 1, -1, 1'b0);
    no = 0;
    for (int i = 0; i < n; i++) begin
      if (o_done[i] == 2'b01 && no < 8) begin owners[no] = 0; no++; end
      else if (o_done[i] == 2'b10 && no < 8) begin owners[no] = 1; no++; end
    end
    for (int k = 0; k < 6; k++) begin
      chk_n++; if (owners[k] != k % 2) $display("FAIL fair_owner burst=%0d got=%0d exp=%0d", k, owners[k], k % 2); else pass_n++;
    end
    // requester 0 drops req two cycles into a 6-beat burst
    do_reset();
    run_cycles(12, 2'b01, 2, 5, 0, -1, 1'b0);
    g0 = 0;
    for (int i = 0; i < 12; i++) if (o_gnt[i] === 2'b01) g0++;
    chk_n++; if (g0 != 6) $display("FAIL drop_beats got=%0d exp=6", g0); else pass_n++;
    chk_n++; if (o_done[6] !== 2'b01) $display("FAIL drop_done got=%b exp=01", o_done[6]); else pass_n++;
  endtask

  // Random req/len/data/reset against a beats-remaining model of the scheduler.
  task automatic test_random();
    int cur, rem, prev, pick;
    bit ingap;
    logic [7:0] m_din;
    logic m_en, m_csn, eb;
    logic [1:0] eg, ed;
    run_cycles(RN, 2'b00, 0, 0, 0, -1, 1'b1);
    cur = -1; rem = 0; prev = 1; ingap = 1'b0; m_din = 8'h00; m_en = 1'b0; m_csn = 1'b1;
    for (int i = 0; i < RN; i++) begin
      eg = (cur == 1) ? 2'b10 : (cur == 0) ? 2'b01 : 2'b00;
      ed = (cur >= 0 && rem == 1) ? eg : 2'b00;
      eb = (cur >= 0) || ingap;
      if (i > 0) begin
        chk_n++; if (o_gnt[i] !== eg) $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", i, o_gnt[i], eg); else pass_n++;
        chk_n++; if (o_done[i] !== ed) $display("FAIL rnd_done cyc=%0d got=%b exp=%b", i, o_done[i], ed); else pass_n++;
        chk_n++; if (o_busy[i] !== eb) $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", i, o_busy[i], eb); else pass_n++;
        chk_n++; if (o_en[i] !== m_en) $display("FAIL rnd_din_en cyc=%0d got=%b exp=%b", i, o_en[i], m_en); else pass_n++;
        chk_n++; if (o_din[i] !== m_din) $display("FAIL rnd_din cyc=%0d got=%h exp=%h", i, o_din[i], m_din); else pass_n++;
        chk_n++; if (o_csn[i] !== m_csn) $display("FAIL rnd_csn cyc=%0d got=%b exp=%b", i, o_csn[i], m_csn); else pass_n++;
      end
      if (r_rst[i]) begin
        cur = -1; rem = 0; prev = 1; ingap = 1'b0; m_din = 8'h00; m_en = 1'b0; m_csn = 1'b1;
      end else begin
        if (cur >= 0) begin
          m_din = (cur == 1) ? r_d1[i] : r_d0[i];
          m_en  = 1'b1;
          m_csn = (cur == 1);
        end else begin
          m_en = 1'b0;
        end
        if (ingap) begin
          ingap = 1'b0;
        end else if (cur >= 0 && rem > 1) begin
          rem--;
        end else if (cur >= 0 && GAP) begin
          cur = -1; ingap = 1'b1;
        end else begin
          if (r_req[i] == 2'b11) pick = 1 - prev;
          else if (r_req[i] == 2'b01) pick = 0;
          else if (r_req[i] == 2'b10) pick = 1;
          else pick = -1;
          cur = pick;
          if (pick >= 0) begin
            prev = pick;
            rem  = ((pick == 1) ? int'(r_l1[i]) : int'(r_l0[i])) + 1;
          end
        end
      end
    end
  endtask

  initial begin
    chk_n = 0;
    pass_n = 0;
    rst = 1'b1;
    bus.req = 2'b00; bus.len0 = '0; bus.len1 = '0; bus.data0 = '0; bus.data1 = '0;
    test_reset();
    test_single_burst();
    test_tie();
    test_min_burst();
    test_reset_mid_burst();
    test_fairness();
    test_random();
    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

endmodule
